spi_register_map: RTL and testbench



---
 rtl/spi_regmap_pkg.sv | 24 ++
 rtl/spi_slave_frontend.sv | 114 +++++++++++
 rtl/spi_register_map.sv | 59 +++++
 tb/tb_spi_register_map.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/spi_regmap_pkg.sv
// rtl/spi_regmap_pkg.sv - shared constants for the SPI register map tile
package spi_regmap_pkg;

  localparam int ADDR_WIDTH     = 7;
  localparam int DATA_WIDTH     = 8;
  localparam int NUM_CONFIG_REG = 96;
  localparam int NUM_STATUS_REG = 32;
  localparam int FRAME_BITS     = 16;
  localparam int BIT_CNT_W      = 5;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [DATA_WIDTH-1:0] STATUS_ZERO = 8'h00;
  localparam logic [DATA_WIDTH-1:0] STATUS_ONES = 8'hFF;

  localparam logic [ADDR_WIDTH-1:0] CFG_END =
    ADDR_WIDTH'(NUM_CONFIG_REG);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ONES_BASE =
    ADDR_WIDTH'(NUM_CONFIG_REG + NUM_STATUS_REG / 2);

  localparam logic [7:0] UIO_OE_VALUE = 8'b1100_0100;

endpackage

// File: rtl/spi_slave_frontend.sv
// rtl/spi_slave_frontend.sv - oversampled SPI mode-0 slave: sync, edge detect, frame decode, SDO shift
module spi_slave_frontend
  import spi_regmap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck_i,
  input  logic                  sdi_i,
  input  logic                  cs_n_i,
  output logic                  addr_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sdo
);

  logic [2:0]            sck_pipe_q, sck_pipe_d;
  logic [1:0]            sdi_pipe_q, sdi_pipe_d;
  logic [1:0]            csn_pipe_q, csn_pipe_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [14:0]           rx_q, rx_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] sdo_sr_q, sdo_sr_d;
  logic                  sdo_q, sdo_d;
  logic                  sck_rise, sck_fall, sdi_s, cs_idle;

  always_comb begin
    sck_pipe_d   = {sck_pipe_q[1:0], sck_i};
    sdi_pipe_d   = {sdi_pipe_q[0], sdi_i};
    csn_pipe_d   = {csn_pipe_q[0], cs_n_i};
    sck_rise     = sck_pipe_q[1] & ~sck_pipe_q[2];
    sck_fall     = ~sck_pipe_q[1] & sck_pipe_q[2];
    sdi_s        = sdi_pipe_q[1];
    cs_idle      = csn_pipe_q[1];
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    sdo_sr_d     = sdo_sr_q;
    sdo_d        = sdo_q;

    // CS_N high wins over any coincident SCK edge and discards partial frames
    if (cs_idle) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      sdo_sr_d  = '0;
      sdo_d     = 1'b0;
    end else begin
      if (addr_valid_q) sdo_sr_d = (rw_q == RW_READ) ? rd_data : '0;
      if (sck_rise && bit_cnt_q < BIT_CNT_W'(FRAME_BITS)) begin
        rx_d      = {rx_q[13:0], sdi_s};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 5'd7) begin
          rw_d         = rx_q[6];
          addr_d       = {rx_q[5:0], sdi_s};
          addr_valid_d = 1'b1;
        end
        if (bit_cnt_q == 5'd15) begin
          wr_en_d   = (rw_q == RW_WRITE);
          wr_data_d = {rx_q[6:0], sdi_s};
        end
      end else if (sck_fall && bit_cnt_q >= 5'd8) begin
        // Zeros shift in behind the data, so falls past bit 0 drive 0
        sdo_d    = sdo_sr_q[7];
        sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_pipe_q   <= '0;
      sdi_pipe_q   <= '0;
      csn_pipe_q   <= 2'b11;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      sdo_sr_q     <= '0;
      sdo_q        <= 1'b0;
    end else begin
      sck_pipe_q   <= sck_pipe_d;
      sdi_pipe_q   <= sdi_pipe_d;
      csn_pipe_q   <= csn_pipe_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      sdo_sr_q     <= sdo_sr_d;
      sdo_q        <= sdo_d;
    end
  end

  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign sdo        = sdo_q;

endmodule

// File: rtl/spi_register_map.sv
// rtl/spi_register_map.sv - Tiny Tapeout top: 96 config bytes + 32 status bytes over SPI
module spi_register_map
  import spi_regmap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [DATA_WIDTH-1:0] cfg_q [NUM_CONFIG_REG];
  logic [DATA_WIDTH-1:0] cfg_d [NUM_CONFIG_REG];
  logic                  addr_valid, wr_en, sdo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic                  unused_inputs;

  assign unused_inputs = &{1'b0, ena, ui_in, uio_in[7:4], uio_in[2], addr_valid};

  spi_slave_frontend u_frontend (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck_i      (uio_in[0]),
    .sdi_i      (uio_in[1]),
    .cs_n_i     (uio_in[3]),
    .addr_valid (addr_valid),
    .addr       (addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .sdo        (sdo)
  );

  always_comb begin
    cfg_d = cfg_q;
    if (wr_en && addr < CFG_END) cfg_d[addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_q <= '{default: '0};
    else        cfg_q <= cfg_d;
  end

  // Lower half of the status window reads as 0x00, upper half as 0xFF
  always_comb begin
    rd_data = STATUS_ONES;
    if (addr < CFG_END)               rd_data = cfg_q[addr];
    else if (addr < STATUS_ONES_BASE) rd_data = STATUS_ZERO;
  end

  assign uo_out  = cfg_q[0];
  assign uio_out = {5'b0, sdo, 2'b0};
  assign uio_oe  = UIO_OE_VALUE;

endmodule

// File: tb/tb_spi_register_map.sv
// tb/tb_spi_register_map.sv - directed + random SPI frames against a behavioural register model
module tb_spi_register_map;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0, sdi = 1'b0, cs_n = 1'b1;
  logic [4:0] junk = 5'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe, uio_in;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model [96];

  assign uio_in = {junk[4:1], cs_n, junk[0], sdi, sck};

  spi_register_map dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_read(input int a);
    if (a < 96)  return model[a];
    if (a < 112) return 8'h00;
    return 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Master side of one CS_N-low period; SDO is sampled 5 clk after each fall,
  // just before the rise on which a mode-0 master would latch it.
  task automatic spi_xfer(input logic [15:0] frame, input int nbits,
                          output logic [7:0] rd, output logic quiet);
    rd    = 8'h00;
    quiet = 1'b1;
    cs_n  = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 16) ? frame[15-i] : 1'($urandom);
      #50;
      if (i >= 8 && i < 16) rd = {rd[6:0], uio_out[2]};
      else if (i < 8 && uio_out[2] !== 1'b0) quiet = 1'b0;
      sck = 1'b1;
      #50;
      sck = 1'b0;
    end
    #50;
    cs_n = 1'b1;
    sdi  = 1'b0;
    #100;
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input int nbits = 16);
    logic [7:0] rd;
    logic       q;
    spi_xfer({1'b0, 7'(a), d}, nbits, rd, q);
    if (a < 96) model[a] = d;
    check("uo_out_after_write", uo_out, model[0]);
  endtask

  task automatic do_read(input string tag, input int a);
    logic [7:0] rd;
    logic       q;
    spi_xfer({1'b1, 7'(a), 8'($urandom)}, 16, rd, q);
    check(tag, rd, ref_read(a));
    check({tag, "_sdo_quiet_hdr"}, {7'b0, q}, 8'h01);
  endtask

  initial begin
    logic [7:0] rd;
    logic       q;
    int         addrs [8] = '{8'h00, 8'h5F, 8'h01, 8'h2A, 8'h30, 8'h44, 8'h50, 8'h5E};

    for (int i = 0; i < 96; i++) model[i] = 8'h00;
    #100;
    rst_n = 1'b1;
    #100;

    check("reset_uo_out", uo_out, 8'h00);
    check("uio_oe", uio_oe, 8'hC4);
    check("reset_uio_out", uio_out, 8'h00);
    do_read("reset_read_00", 8'h00);

    do_write(8'h23, 8'h5A);
    do_read("read_23", 8'h23);
    do_write(8'h00, 8'hA5);
    check("uo_out_A5", uo_out, 8'hA5);

    do_read("status_60", 8'h60);
    do_read("status_6F", 8'h6F);
    do_read("status_70", 8'h70);
    do_read("status_7F", 8'h7F);
    do_write(8'h65, 8'h12);
    do_read("status_65_after_write", 8'h65);

    for (int i = 0; i < 8; i++) do_write(addrs[i], 8'(8'h1F + 8'd29 * i));
    for (int i = 0; i < 8; i++) do_read("write_all_readback", addrs[i]);

    do_write(8'h10, 8'h3C);
    spi_xfer({1'b0, 7'h10, 8'h77}, 12, rd, q);
    do_read("aborted_write_10", 8'h10);
    do_write(8'h10, 8'h99);
    do_read("after_abort_10", 8'h10);

    do_write(8'h11, 8'hC3, 21);
    do_read("extra_clocks_11", 8'h11);
    do_read("extra_clocks_10", 8'h10);

    for (int n = 0; n < 40; n++) begin
      int a;
      junk  = 5'($urandom);
      ui_in = 8'($urandom);
      a     = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
      else                           do_read("random_read", a);
    end
    junk = 5'b0;

    // Mid-read reset: 0x23 holds 0xE7, so SDO is high after the 9th fall
    do_write(8'h00, 8'hA5);
    do_write(8'h23, 8'hE7);
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < 9; i++) begin
      sdi = (i == 0) ? 1'b1 : ((7'h23 >> (7 - i)) & 1'b1);
      #50 sck = 1'b1;
      #50 sck = 1'b0;
    end
    #50;
    check("sdo_before_reset", {7'b0, uio_out[2]}, 8'h01);
    rst_n = 1'b0;
    #20;
    check("sdo_in_reset", uio_out, 8'h00);
    check("uo_out_in_reset", uo_out, 8'h00);
    for (int i = 0; i < 96; i++) model[i] = 8'h00;
    #40;
    rst_n = 1'b1;
    #40;
    cs_n = 1'b1;
    sdi  = 1'b0;
    #100;
    do_read("read_23_after_reset", 8'h23);
    do_read("read_00_after_reset", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
